// File: rtl/seq_shift_add_multiplier_if.sv
// seq_shift_add_multiplier_if: start/busy/done handshake and operand/product bus for the multiplier
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: unsigned WIDTHxWIDTH shift-and-add multiplier, one ripple add per cycle
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_shift_add_multiplier_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t             state_q;
  logic [WIDTH-1:0]   acc_q, q_q, m_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   addend, sum;
  logic [WIDTH:0]     carry;
  logic [WIDTH-1:0]   acc_d, q_d;
  assign addend   = q_q[0] ? m_q : '0;
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = acc_q[i] ^ addend[i] ^ carry[i];
    assign carry[i+1] = (acc_q[i] & addend[i]) | (carry[i] & (acc_q[i] ^ addend[i]));
  end
  // carry-out lands in the accumulator MSB so the full product stays exact
  assign acc_d = {carry[WIDTH], sum[WIDTH-1:1]};
  assign q_d   = {sum[0], q_q[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          m_q     <= bus.a;
          q_q     <= bus.b;
          acc_q   <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = {acc_q, q_q};
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: randomized and directed checks against a plain A*B reference
module tb_seq_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  seq_shift_add_multiplier_if #(.WIDTH(8)) mif ();
  seq_shift_add_multiplier #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(mif));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept at the next edge, scramble operands mid-run, and expect done 8 edges after acceptance
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [15:0] exp;
    int edges;
    exp = 16'(a) * 16'(b);
    mif.start = 1'b1;
    mif.a = a;
    mif.b = b;
    tick();
    mif.start = 1'b0;
    edges = 0;
    while (!mif.done && edges < 20) begin
      mif.a = 8'($urandom);
      mif.b = 8'($urandom);
      if (edges > 0 && mif.busy !== 1'b1) check({tag, " busy_calc"}, 32'(mif.busy), 32'd1);
      tick();
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'd8);
    check({tag, " product"}, 32'(mif.product), 32'(exp));
    check({tag, " busy_at_done"}, 32'(mif.busy), 32'd0);
    tick();
    check({tag, " done_pulse"}, 32'(mif.done), 32'd0);
  endtask

  initial begin
    int done_at[$];
    logic [15:0] prod_at[$];
    int pulses;
    mif.start = 1'b0;
    mif.a = '0;
    mif.b = '0;
    tick();
    tick();
    check("reset busy", 32'(mif.busy), 32'd0);
    check("reset done", 32'(mif.done), 32'd0);
    check("reset product", 32'(mif.product), 32'd0);
    rst = 1'b0;
    tick();
    do_mul(8'h0F, 8'h0F, "0fx0f");
    check("0fx0f value", 32'(mif.product), 32'h00E1);
    do_mul(8'hFF, 8'hFF, "ffxff");
    check("ffxff value", 32'(mif.product), 32'hFE01);
    do_mul(8'h00, 8'h5A, "00x5a");
    // start held high: each accept follows the previous done's return to idle
    mif.start = 1'b1;
    mif.a = 8'h03;
    mif.b = 8'h05;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (mif.done) begin
        done_at.push_back(k);
        prod_at.push_back(mif.product);
      end
    end
    mif.start = 1'b0;
    check("held done count", 32'(done_at.size()), 32'd2);
    if (done_at.size() == 2) begin
      check("held spacing", 32'(done_at[1] - done_at[0]), 32'd10);
      check("held prod0", 32'(prod_at[0]), 32'h000F);
      check("held prod1", 32'(prod_at[1]), 32'h000F);
    end
    tick();
    // abort mid-calculation
    mif.start = 1'b1;
    mif.a = 8'h12;
    mif.b = 8'h34;
    tick();
    mif.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(mif.busy), 32'd0);
    check("abort product", 32'(mif.product), 32'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (mif.done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    do_mul(8'h12, 8'h34, "12x34");
    check("12x34 value", 32'(mif.product), 32'h03A8);
    do_mul(8'h10, 8'h10, "10x10");
    for (int k = 0; k < 50; k++) begin
      mif.a = 8'($urandom);
      mif.b = 8'($urandom);
      tick();
      check("hold product", 32'(mif.product), 32'h0100);
    end
    for (int k = 0; k < 1000; k++) do_mul(8'($urandom), 8'($urandom), "rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
